// File: rtl/bandpower_stream_ctrl_pkg.sv
// Shared types and helpers for the bandpower stream controller.
//   state_e   : result-path FSM states (HDR is reachable only when
//               BPSTREAM_HEADER_EN is defined)
//   HDR_TAG   : upper nibble of the frame header word
//   idx_width : width of the band index counter, at least one bit
package bandpower_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    ARM  = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam logic [3:0] HDR_TAG = 4'hA;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bandpower_stream_ctrl_if.sv
// Bus bundle between the SPI slave / bandpower blocks and the stream controller.
//   slave  modport : controller view (takes i_*, drives o_*)
//   master modport : environment view (drives i_*, takes o_*)
// Signals:
//   i_enable, i_rx_data, i_rx_ready : SPI RX side and sample gating
//   o_x, o_wr                       : sample + write strobe into bandpower
//   i_y, i_done                     : band powers, band b at [b*WIDTH +: WIDTH]
//   i_tx_ready, o_tx_data           : SPI TX handshake and word
//   o_busy, o_overrun_cnt           : frame status
interface bandpower_stream_ctrl_if #(
  parameter int WIDTH       = 16,
  parameter int BAND_NUM    = 2,
  parameter int SPI_S_WIDTH = 16,
  parameter int SPI_M_WIDTH = 16,
  parameter int OVR_W       = 8
);
  logic                      i_enable;
  logic [SPI_S_WIDTH-1:0]    i_rx_data;
  logic                      i_rx_ready;
  logic [SPI_S_WIDTH-1:0]    o_x;
  logic                      o_wr;
  logic [BAND_NUM*WIDTH-1:0] i_y;
  logic                      i_done;
  logic                      i_tx_ready;
  logic [SPI_M_WIDTH-1:0]    o_tx_data;
  logic                      o_busy;
  logic [OVR_W-1:0]          o_overrun_cnt;

  modport slave (
    input  i_enable, i_rx_data, i_rx_ready, i_y, i_done, i_tx_ready,
    output o_x, o_wr, o_tx_data, o_busy, o_overrun_cnt
  );

  modport master (
    output i_enable, i_rx_data, i_rx_ready, i_y, i_done, i_tx_ready,
    input  o_x, o_wr, o_tx_data, o_busy, o_overrun_cnt
  );
endinterface

// File: rtl/bandpower_stream_ctrl_edge.sv
// Registered rising-edge detector.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   d     : level input
//   rise  : high while d is high and was low at the previous clock edge
module bandpower_stream_ctrl_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/bandpower_stream_ctrl.sv
// Glue between the SPI slave and bandpower, for BAND_NUM bands.
//   Sample path : each new SPI RX word becomes one o_wr pulse (latency 1).
//   Result path : band powers are snapshotted on a rising i_done and sent
//                 one word per SPI TX handshake; a rise while a frame is in
//                 flight is dropped and counted (saturating).
// Ports:
//   i_sys_clk : clock, all logic on posedge
//   i_sys_rst : asynchronous active-low reset
//   bus       : bandpower_stream_ctrl_if.slave (see interface file)
// Optional feature: define BPSTREAM_HEADER_EN to prefix every frame with a
// header word {4'hA, seq[3:0], BAND_NUM[7:0]} MSB-aligned to SPI_M_WIDTH.
module bandpower_stream_ctrl
  import bandpower_stream_ctrl_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int BAND_NUM    = 2,
  parameter int SPI_S_WIDTH = 16,
  parameter int SPI_M_WIDTH = 16,
  parameter int OVR_W       = 8
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst,
  bandpower_stream_ctrl_if.slave  bus
);

  localparam int                IDX_W    = idx_width(BAND_NUM);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BAND_NUM - 1);

  function automatic logic [SPI_M_WIDTH-1:0] sext_word(input logic signed [WIDTH-1:0] w);
    return SPI_M_WIDTH'(w);
  endfunction

`ifdef BPSTREAM_HEADER_EN
  localparam logic [7:0] BN8 = 8'(BAND_NUM);

  function automatic logic [SPI_M_WIDTH-1:0] hdr_word(input logic [3:0] s);
    logic [15:0]              h;
    logic [SPI_M_WIDTH+15:0]  t;
    h = {HDR_TAG, s, BN8};
    t = {h, {SPI_M_WIDTH{1'b0}}};
    return t[SPI_M_WIDTH+15 -: SPI_M_WIDTH];
  endfunction
`endif

  // ---- sample path: one pulse per RX word ----
  logic [SPI_S_WIDTH-1:0] rx_word;
  logic [SPI_S_WIDTH-1:0] x_p1;
  logic                   wr_p1;
  logic                   armed;

  assign rx_word = bus.i_rx_data;

  // A word is consumed on the first cycle of i_rx_ready whether or not it is
  // forwarded, so a late i_enable cannot resurrect a discarded word.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      armed <= 1'b0;
      wr_p1 <= 1'b0;
      x_p1  <= '0;
    end else begin
      wr_p1 <= 1'b0;
      if (!bus.i_rx_ready) begin
        armed <= 1'b1;
      end else if (armed) begin
        armed <= 1'b0;
        if (bus.i_enable) begin
          wr_p1 <= 1'b1;
          x_p1  <= rx_word;
        end
      end
    end
  end

  assign bus.o_x  = x_p1;
  assign bus.o_wr = wr_p1;

  // ---- result path ----
  logic done_rise;

  bandpower_stream_ctrl_edge u_done_edge (
    .clk   (i_sys_clk),
    .rst_n (i_sys_rst),
    .d     (bus.i_done),
    .rise  (done_rise)
  );

  state_e                   state_q, state_d;
  logic signed [WIDTH-1:0]  snap [BAND_NUM];
  logic [IDX_W-1:0]         idx_q;
  logic [SPI_M_WIDTH-1:0]   tx_q;
  logic                     busy_q;
  logic [OVR_W-1:0]         ovr_q;

  logic take_snap, load_word, idx_inc, frame_end, overrun;
`ifdef BPSTREAM_HEADER_EN
  logic       load_hdr;
  logic       hdr_sent_q;
  logic [3:0] seq_q;
`endif

  always_comb begin
    state_d   = state_q;
    take_snap = 1'b0;
    load_word = 1'b0;
    idx_inc   = 1'b0;
    frame_end = 1'b0;
`ifdef BPSTREAM_HEADER_EN
    load_hdr  = 1'b0;
`endif
    overrun   = done_rise && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (done_rise) begin
          take_snap = 1'b1;
`ifdef BPSTREAM_HEADER_EN
          state_d   = HDR;
`else
          state_d   = ARM;
`endif
        end
      end
`ifdef BPSTREAM_HEADER_EN
      // HDR covers both halves of the header handshake; hdr_sent_q tells
      // them apart.
      HDR: begin
        if (!hdr_sent_q) begin
          if (bus.i_tx_ready) load_hdr = 1'b1;
        end else if (!bus.i_tx_ready) begin
          state_d = ARM;
        end
      end
`endif
      ARM: begin
        if (bus.i_tx_ready) begin
          load_word = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (!bus.i_tx_ready) begin
          if (idx_q == LAST_IDX) begin
            frame_end = 1'b1;
            state_d   = IDLE;
          end else begin
            idx_inc = 1'b1;
            state_d = ARM;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      idx_q  <= '0;
      tx_q   <= '0;
      busy_q <= 1'b0;
      ovr_q  <= '0;
    end else begin
      if (take_snap) begin
        idx_q  <= '0;
        busy_q <= 1'b1;
      end
      if (idx_inc)   idx_q <= idx_q + 1'b1;
      if (load_word) tx_q  <= sext_word(snap[idx_q]);
`ifdef BPSTREAM_HEADER_EN
      if (load_hdr)  tx_q  <= hdr_word(seq_q);
`endif
      if (frame_end) begin
        tx_q   <= '0;
        busy_q <= 1'b0;
      end
      if (overrun && (ovr_q != {OVR_W{1'b1}})) ovr_q <= ovr_q + 1'b1;
    end
  end

`ifdef BPSTREAM_HEADER_EN
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      hdr_sent_q <= 1'b0;
      seq_q      <= '0;
    end else begin
      if (take_snap)      hdr_sent_q <= 1'b0;
      else if (load_hdr)  hdr_sent_q <= 1'b1;
      if (frame_end)      seq_q      <= seq_q + 1'b1;
    end
  end
`endif

  // ---- snapshot buffer: data only, left unreset ----
  always_ff @(posedge i_sys_clk) begin
    if (take_snap) begin
      for (int b = 0; b < BAND_NUM; b++) begin
        snap[b] <= bus.i_y[b*WIDTH +: WIDTH];
      end
    end
  end

  assign bus.o_tx_data     = tx_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_overrun_cnt = ovr_q;

endmodule

// File: tb/tb_bandpower_stream_ctrl.sv
module tb_bandpower_stream_ctrl;
  localparam int W  = 16;
`ifdef BPSTREAM_HEADER_EN
  localparam int BN = 4;
  localparam int HW = 1;
`else
  localparam int BN = 2;
  localparam int HW = 0;
`endif
  localparam int SW    = 16;
  localparam int MW    = 16;
  localparam int OVR_W = 8;
  localparam int L     = HW + BN;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bandpower_stream_ctrl_if #(.WIDTH(W), .BAND_NUM(BN), .SPI_S_WIDTH(SW),
                             .SPI_M_WIDTH(MW), .OVR_W(OVR_W)) bus ();

  bandpower_stream_ctrl #(.WIDTH(W), .BAND_NUM(BN), .SPI_S_WIDTH(SW),
                          .SPI_M_WIDTH(MW), .OVR_W(OVR_W)) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;
  int seq_m = 0;

  logic [MW-1:0]          exp_q [$];
  logic [SW-1:0]          x_q   [$];
  logic signed [W-1:0]    yv    [BN];

  typedef struct {
    logic        en;
    logic [15:0] data;
    int          hi;
    int          en_rise;
    int          exp_n;
  } rx_vec_t;
  rx_vec_t rv [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive_y();
    for (int b = 0; b < BN; b++) bus.i_y[b*W +: W] = yv[b];
  endtask

  task automatic start_frame();
    logic [15:0] h;
    drive_y();
    if (HW == 1) begin
      h = {4'hA, 4'(seq_m), 8'(BN)};
      exp_q.push_back(MW'(h));
    end
    for (int b = 0; b < BN; b++) exp_q.push_back(MW'(yv[b]));
    bus.i_done = 1'b1;
    tick();
    bus.i_done = 1'b0;
    chk("busy_start", 32'(bus.o_busy), 32'd1);
  endtask

  task automatic run_words(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_tx_ready = 1'b1;
      tick();
      if (exp_q.size() == 0) chk("tx_queue_empty", 32'(exp_q.size()), 32'd1);
      else                   chk("tx_word", 32'(bus.o_tx_data), 32'(exp_q.pop_front()));
      bus.i_tx_ready = 1'b0;
      tick();
    end
  endtask

  task automatic end_frame_check();
    chk("tx_end_zero", 32'(bus.o_tx_data), 32'd0);
    chk("busy_end",    32'(bus.o_busy),    32'd0);
    seq_m++;
  endtask

  initial begin
    int pulses, first;

    rv[0] = '{en:1'b1, data:16'h0123, hi:5, en_rise:-1, exp_n:1};
    rv[1] = '{en:1'b0, data:16'hBEEF, hi:4, en_rise:2,  exp_n:0};
    rv[2] = '{en:1'b1, data:16'h8000, hi:1, en_rise:-1, exp_n:1};
    rv[3] = '{en:1'b0, data:16'h1111, hi:3, en_rise:-1, exp_n:0};
    rv[4] = '{en:1'b1, data:16'hFFFF, hi:2, en_rise:-1, exp_n:1};

    bus.i_enable   = 1'b0;
    bus.i_rx_data  = '0;
    bus.i_rx_ready = 1'b0;
    bus.i_y        = '0;
    bus.i_done     = 1'b0;
    bus.i_tx_ready = 1'b0;

    tick();
    chk("rst_wr",   32'(bus.o_wr),          32'd0);
    chk("rst_x",    32'(bus.o_x),           32'd0);
    chk("rst_tx",   32'(bus.o_tx_data),     32'd0);
    chk("rst_busy", 32'(bus.o_busy),        32'd0);
    chk("rst_ovr",  32'(bus.o_overrun_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // RX vectors
    for (int v = 0; v < 5; v++) begin
      bus.i_enable   = rv[v].en;
      bus.i_rx_data  = rv[v].data;
      bus.i_rx_ready = 1'b1;
      if (rv[v].exp_n > 0) x_q.push_back(rv[v].data);
      pulses = 0;
      first  = -1;
      for (int c = 0; c < rv[v].hi + 2; c++) begin
        if (c == rv[v].en_rise) bus.i_enable = 1'b1;
        if (c == rv[v].hi) bus.i_rx_ready = 1'b0;
        tick();
        if (bus.o_wr) begin
          pulses++;
          if (first < 0) first = c;
          if (x_q.size() != 0) chk($sformatf("rx_x_%0d", v), 32'(bus.o_x), 32'(x_q.pop_front()));
        end
      end
      chk($sformatf("rx_pulses_%0d", v), 32'(pulses), 32'(rv[v].exp_n));
      if (rv[v].exp_n > 0) chk($sformatf("rx_latency_%0d", v), 32'(first), 32'd0);
      chk($sformatf("rx_q_%0d", v), 32'(x_q.size()), 32'd0);
      bus.i_enable = 1'b1;
    end

    // Basic frame
    yv[0] = 16'sd100;
    yv[1] = -16'sd3;
    for (int b = 2; b < BN; b++) yv[b] = (b == 2) ? 16'sd7 : -16'sd32768;
    start_frame();
    chk("tx_before_ready", 32'(bus.o_tx_data), 32'd0);
    run_words(L);
    end_frame_check();

    // Overrun: drops leave the first snapshot in place
    for (int b = 0; b < BN; b++) yv[b] = W'(11 * (b + 1));
    start_frame();
    bus.i_tx_ready = 1'b1;
    tick();
    chk("ovr_first_word", 32'(bus.o_tx_data), 32'(exp_q.pop_front()));
    bus.i_y    = {BN{16'h7777}};
    bus.i_done = 1'b1;
    tick();
    bus.i_done = 1'b0;
    tick();
    chk("ovr_one", 32'(bus.o_overrun_cnt), 32'd1);
    bus.i_tx_ready = 1'b0;
    tick();
    bus.i_done = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.i_done = 1'b0;
    tick();
    chk("ovr_two", 32'(bus.o_overrun_cnt), 32'd2);
    run_words(L - 1);
    end_frame_check();

    // Sample and result events in the same cycle
    for (int b = 0; b < BN; b++) yv[b] = W'(-5 - b);
    drive_y();
    if (HW == 1) exp_q.push_back(MW'({4'hA, 4'(seq_m), 8'(BN)}));
    for (int b = 0; b < BN; b++) exp_q.push_back(MW'(yv[b]));
    bus.i_rx_data  = 16'h5A5A;
    bus.i_rx_ready = 1'b1;
    bus.i_done     = 1'b1;
    tick();
    bus.i_done     = 1'b0;
    bus.i_rx_ready = 1'b0;
    chk("sim_wr",   32'(bus.o_wr),   32'd1);
    chk("sim_x",    32'(bus.o_x),    32'h5A5A);
    chk("sim_busy", 32'(bus.o_busy), 32'd1);
    run_words(L);
    end_frame_check();

    // Overrun counter saturation
    start_frame();
    for (int i = 0; i < 260; i++) begin
      bus.i_done = 1'b1;
      tick();
      bus.i_done = 1'b0;
      tick();
    end
    chk("ovr_sat", 32'(bus.o_overrun_cnt), 32'hFF);
    run_words(L);
    end_frame_check();

    // Asynchronous reset in ARM
    for (int b = 0; b < BN; b++) yv[b] = W'(300 + b);
    start_frame();
    run_words(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tx",   32'(bus.o_tx_data),     32'd0);
    chk("arst_busy", 32'(bus.o_busy),        32'd0);
    chk("arst_ovr",  32'(bus.o_overrun_cnt), 32'd0);
    exp_q.delete();
    seq_m = 0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int b = 0; b < BN; b++) yv[b] = W'(-1 - 2 * b);
    start_frame();
    run_words(L);
    end_frame_check();

`ifdef BPSTREAM_HEADER_EN
    // Second header of this run must carry seq 1
    for (int b = 0; b < BN; b++) yv[b] = W'(b);
    start_frame();
    chk("hdr_seq_expect", 32'(exp_q[0]), 32'(16'hA104));
    run_words(L);
    end_frame_check();
`endif

    chk("tx_q_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
